// File: rtl/pc_rx_packet_decoder.sv
// rtl/pc_rx_packet_decoder.sv - PC_RX packet framing decoder between the RX FIFO and the DataManager
//
// Purpose: pulls 32-bit words from the PC_RX FIFO one at a time, tracks the
// RESYNC / MAGIC / length framing and forwards only payload words.
//
// Ports:
//   i_clock, i_reset_n      clock, asynchronous active-low reset
//   i_fifo_word/empty       FIFO read data (valid the cycle after rdreq) and empty flag
//   o_fifo_rdreq            single-cycle FIFO read request
//   o_payload_word/valid    payload word and valid toward the DataManager
//   i_payload_ready         DataManager ready; transfer on valid && ready
//   o_start_packet_sig      pulse when a legal length header is accepted
//   o_packet_done_sig       pulse on the handshake of the last payload word
//   o_state                 0 IDLE, 1 PRE, 2 LEN, 3 DATA
//   o_resync_err_count      saturating count of RESYNC seen in LEN or DATA
//   o_len_err_count         saturating count of illegal length headers
module pc_rx_packet_decoder #(
    parameter logic [31:0] RESYNC_WORD = 32'h416FDC1E,
    parameter logic [31:0] MAGIC_WORD  = 32'hD78C1B74,
    parameter int          MAX_LEN     = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_fifo_word,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rdreq,
    output logic [31:0] o_payload_word,
    output logic        o_payload_valid,
    input  logic        i_payload_ready,
    output logic        o_start_packet_sig,
    output logic        o_packet_done_sig,
    output logic [1:0]  o_state,
    output logic [7:0]  o_resync_err_count,
    output logic [7:0]  o_len_err_count
);

    localparam int          CW        = $clog2(MAX_LEN + 1);
    localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t        state;
    logic          rd_pending;
    logic [CW-1:0] word_cnt;
    logic          handshake;
    logic          is_resync;
    logic          len_ok;

    assign handshake = o_payload_valid && i_payload_ready;
    assign is_resync = (i_fifo_word == RESYNC_WORD);
    assign len_ok    = (i_fifo_word != 32'd0) && (i_fifo_word <= MAX_LEN_W);

    // A read may only be issued when nothing is in flight and the output
    // register is free (or being freed this cycle), so the decoder never has
    // to buffer more than one word and the FIFO absorbs all backpressure.
    assign o_fifo_rdreq = i_reset_n && !i_fifo_empty && !rd_pending &&
                          (!o_payload_valid || i_payload_ready);

    assign o_packet_done_sig = handshake && (state == DATA) && (word_cnt == CW'(1));
    assign o_state           = state;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state              <= IDLE;
            rd_pending         <= 1'b0;
            word_cnt           <= '0;
            o_payload_word     <= '0;
            o_payload_valid    <= 1'b0;
            o_start_packet_sig <= 1'b0;
            o_resync_err_count <= '0;
            o_len_err_count    <= '0;
        end else begin
            rd_pending         <= o_fifo_rdreq;
            o_start_packet_sig <= 1'b0;

            if (handshake) begin
                o_payload_valid <= 1'b0;
                word_cnt        <= word_cnt - CW'(1);
                if (word_cnt == CW'(1)) begin
                    state <= IDLE;
                end
            end

            // A sampled word never coincides with a held payload word, so the
            // classification below cannot collide with the handshake above.
            if (rd_pending) begin
                case (state)
                    IDLE: begin
                        if (is_resync) state <= PRE;
                    end
                    PRE: begin
                        if (i_fifo_word == MAGIC_WORD) state <= LEN;
                        else if (is_resync)            state <= PRE;
                        else                           state <= IDLE;
                    end
                    LEN: begin
                        if (is_resync) begin
                            state <= PRE;
                            if (o_resync_err_count != 8'hFF)
                                o_resync_err_count <= o_resync_err_count + 8'd1;
                        end else if (len_ok) begin
                            word_cnt           <= i_fifo_word[CW-1:0];
                            state              <= DATA;
                            o_start_packet_sig <= 1'b1;
                        end else begin
                            state <= IDLE;
                            if (o_len_err_count != 8'hFF)
                                o_len_err_count <= o_len_err_count + 8'd1;
                        end
                    end
                    DATA: begin
                        if (is_resync) begin
                            state <= PRE;
                            if (o_resync_err_count != 8'hFF)
                                o_resync_err_count <= o_resync_err_count + 8'd1;
                        end else begin
                            o_payload_word  <= i_fifo_word;
                            o_payload_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_rx_packet_decoder.sv
// tb/tb_pc_rx_packet_decoder.sv - self-checking bench for pc_rx_packet_decoder
module tb_pc_rx_packet_decoder;

    localparam logic [31:0] RES = 32'h416FDC1E;
    localparam logic [31:0] MAG = 32'hD78C1B74;
    localparam int          MAXL = 1024;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic [31:0] fifo_word = '0;
    logic        fifo_empty = 1'b1;
    logic        rdreq;
    logic [31:0] pw;
    logic        pv;
    logic        ready;
    logic        sp, pd;
    logic [1:0]  st;
    logic [7:0]  rerr, lerr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 i_clock = ~i_clock;

    pc_rx_packet_decoder dut (
        .i_clock            (i_clock),
        .i_reset_n          (i_reset_n),
        .i_fifo_word        (fifo_word),
        .i_fifo_empty       (fifo_empty),
        .o_fifo_rdreq       (rdreq),
        .o_payload_word     (pw),
        .o_payload_valid    (pv),
        .i_payload_ready    (ready),
        .o_start_packet_sig (sp),
        .o_packet_done_sig  (pd),
        .o_state            (st),
        .o_resync_err_count (rerr),
        .o_len_err_count    (lerr)
    );

    // Normal-mode FIFO: q appears the cycle after the read request.
    logic [31:0] fq[$];
    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        if (rdreq && fq.size() > 0) fifo_word <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Observation of handshakes, pulses and holding rules.
    logic [31:0] got[$];
    int          got_cyc[$];
    logic [31:0] done_word[$];
    int          n_start = 0;
    int          n_done  = 0;
    int          viol    = 0;
    logic        held    = 1'b0;
    logic [31:0] held_word = '0;

    always @(negedge i_clock) begin
        if (i_reset_n) begin
            if (held && (!pv || pw !== held_word)) viol++;
            if (pv && !ready && rdreq) viol++;
            if (pv && ready) begin
                got.push_back(pw);
                got_cyc.push_back(cyc);
            end
            if (sp) n_start++;
            if (pd) begin
                n_done++;
                done_word.push_back(pw);
            end
            held      = pv && !ready;
            held_word = pw;
        end else begin
            held = 1'b0;
        end
    end

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == RES) w = 32'h1234_5678;
        return w;
    endfunction

    // Word-level reference of the framing rules: which words become payload,
    // how many starts/dones/errors occur and where the framing ends up.
    task automatic model(input logic [31:0] w[$], output logic [31:0] exp[$],
                         output int starts, output int dones, output int rerrs,
                         output int lerrs, output int fstate, output logic [31:0] last_done);
        int mode;
        int remaining;
        mode = 0; remaining = 0;
        starts = 0; dones = 0; rerrs = 0; lerrs = 0; last_done = '0;
        exp.delete();
        foreach (w[i]) begin
            if (mode == 0) begin
                if (w[i] == RES) mode = 1;
            end else if (mode == 1) begin
                if (w[i] == MAG) mode = 2;
                else if (w[i] == RES) mode = 1;
                else mode = 0;
            end else if (mode == 2) begin
                if (w[i] == RES) begin
                    rerrs++; mode = 1;
                end else if (w[i] >= 1 && w[i] <= MAXL) begin
                    remaining = int'(w[i]); starts++; mode = 3;
                end else begin
                    lerrs++; mode = 0;
                end
            end else begin
                if (w[i] == RES) begin
                    rerrs++; mode = 1;
                end else begin
                    exp.push_back(w[i]);
                    remaining--;
                    if (remaining == 0) begin
                        dones++; last_done = w[i]; mode = 0;
                    end
                end
            end
        end
        fstate = mode;
    endtask

    // Feeds a stream (behind anything still in the FIFO) and compares the
    // observed behaviour with the model. rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic run(input logic [31:0] nw[$], input int rmode, input string name);
        logic [31:0] all[$];
        logic [31:0] exp[$];
        logic [31:0] last_done;
        int starts, dones, rerrs, lerrs, fstate, r0, l0, limit, k, er, el;
        all = fq;
        foreach (nw[i]) all.push_back(nw[i]);
        model(all, exp, starts, dones, rerrs, lerrs, fstate, last_done);
        @(negedge i_clock);
        got.delete(); got_cyc.delete(); done_word.delete();
        n_start = 0; n_done = 0; viol = 0;
        r0 = int'(rerr); l0 = int'(lerr);
        foreach (nw[i]) fq.push_back(nw[i]);
        limit = 40 * all.size() + 100;
        k = 0;
        while (fq.size() > 0 && k < limit) begin
            @(posedge i_clock); #2;
            if (rmode == 0)      ready = 1'b1;
            else if (rmode == 1) ready = ((k % 4) == 0) || ((k % 4) == 3);
            else                 ready = 1'($urandom_range(0, 1));
            k++;
        end
        total++;
        if (k >= limit) begin
            bad++;
            $display("FAIL %s timeout: fifo words left=%0d want=0", name, fq.size());
        end
        for (int d = 0; d < 12; d++) begin
            @(posedge i_clock); #2;
            ready = 1'b1;
        end
        @(negedge i_clock);
        total++;
        if (got.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s payload count got=%0d want=%0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL %s payload[%0d] got=%h want=%h", name, i, got[i], exp[i]);
            end
        end
        total++;
        if (n_start !== starts) begin
            bad++;
            $display("FAIL %s start pulses got=%0d want=%0d", name, n_start, starts);
        end
        total++;
        if (n_done !== dones) begin
            bad++;
            $display("FAIL %s done pulses got=%0d want=%0d", name, n_done, dones);
        end
        if (dones > 0 && done_word.size() > 0) begin
            total++;
            if (done_word[done_word.size()-1] !== last_done) begin
                bad++;
                $display("FAIL %s done word got=%h want=%h", name,
                         done_word[done_word.size()-1], last_done);
            end
        end
        er = (r0 + rerrs > 255) ? 255 : r0 + rerrs;
        el = (l0 + lerrs > 255) ? 255 : l0 + lerrs;
        total++;
        if (int'(rerr) !== er) begin
            bad++;
            $display("FAIL %s resync err count got=%0d want=%0d", name, rerr, er);
        end
        total++;
        if (int'(lerr) !== el) begin
            bad++;
            $display("FAIL %s len err count got=%0d want=%0d", name, lerr, el);
        end
        total++;
        if (int'(st) !== fstate) begin
            bad++;
            $display("FAIL %s final state got=%0d want=%0d", name, st, fstate);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL %s hold/rdreq violations got=%0d want=0", name, viol);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        ready     = 1'b1;
        repeat (3) @(posedge i_clock);
        #2;
        total++;
        if ({pv, sp, pd, rdreq} !== 4'b0000) begin
            bad++;
            $display("FAIL reset strobes got=%b want=0000", {pv, sp, pd, rdreq});
        end
        total++;
        if (st !== 2'd0) begin
            bad++;
            $display("FAIL reset state got=%0d want=0", st);
        end
        total++;
        if ({rerr, lerr} !== 16'd0 || pw !== 32'd0) begin
            bad++;
            $display("FAIL reset counters/word got=%h/%h/%h want=0", rerr, lerr, pw);
        end
        @(negedge i_clock);
        i_reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] s[$];
        s = '{RES, MAG, 32'd3, 32'h11111111, 32'h22222222, 32'h33333333};
        run(s, 0, "basic");
        total++;
        if (got_cyc.size() < 3 || got_cyc[1] - got_cyc[0] != 2 || got_cyc[2] - got_cyc[1] != 2) begin
            bad++;
            $display("FAIL basic spacing got=%0d handshakes want=3 at 2-cycle spacing", got_cyc.size());
        end
    endtask

    task automatic test_garbage();
        logic [31:0] s[$];
        s = '{32'h12345678, 32'hAAAAAAAA, RES, 32'h00000000};
        run(s, 0, "garbage");
    endtask

    task automatic test_len_err();
        logic [31:0] s[$];
        s = '{RES, MAG, 32'd0, RES, MAG, 32'(MAXL + 1)};
        run(s, 0, "len_err");
        total++;
        if (lerr !== 8'd2) begin
            bad++;
            $display("FAIL len_err absolute count got=%0d want=2", lerr);
        end
    endtask

    task automatic test_resync_mid();
        logic [31:0] s[$];
        s = '{RES, MAG, 32'd4, 32'hA0A0A0A0, 32'hB1B1B1B1, RES, MAG, 32'd1, 32'hCAFEF00D};
        run(s, 0, "resync_mid");
        total++;
        if (rerr !== 8'd1 || got.size() != 3) begin
            bad++;
            $display("FAIL resync_mid rerr/words got=%0d/%0d want=1/3", rerr, got.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s[$];
        s = '{RES, MAG, 32'd5};
        for (int i = 0; i < 5; i++) s.push_back(rnd_word());
        run(s, 1, "backpressure");
    endtask

    task automatic test_max_len();
        logic [31:0] s[$];
        s = '{RES, MAG, 32'(MAXL)};
        for (int i = 0; i < MAXL; i++) s.push_back((i == 7) ? MAG : rnd_word());
        run(s, 0, "max_len");
    endtask

    task automatic test_random();
        logic [31:0] s[$];
        int n;
        for (int it = 0; it < 4; it++) begin
            s.delete();
            for (int seg = 0; seg < 12; seg++) begin
                case ($urandom_range(0, 4))
                    0: s.push_back(rnd_word());
                    1: begin
                        n = $urandom_range(1, 6);
                        s.push_back(RES); s.push_back(MAG); s.push_back(32'(n));
                        for (int j = 0; j < n; j++) s.push_back(rnd_word());
                    end
                    2: begin
                        s.push_back(RES); s.push_back(MAG);
                        s.push_back(($urandom_range(0, 1) == 0) ? 32'd0 : 32'(MAXL + 1 + $urandom_range(0, 999)));
                    end
                    3: begin
                        s.push_back(RES); s.push_back(MAG); s.push_back(32'd5);
                        s.push_back(rnd_word()); s.push_back(rnd_word());
                    end
                    default: begin
                        s.push_back(RES); s.push_back(rnd_word());
                    end
                endcase
            end
            s.push_back(RES); s.push_back(MAG); s.push_back(32'd1); s.push_back(rnd_word());
            run(s, 2, "random");
        end
    endtask

    task automatic test_saturation();
        logic [31:0] s[$];
        for (int i = 0; i < 260; i++) begin
            s.push_back(RES); s.push_back(MAG); s.push_back(32'd0);
        end
        run(s, 0, "saturation");
        total++;
        if (lerr !== 8'd255) begin
            bad++;
            $display("FAIL saturation len err got=%0d want=255", lerr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s[$];
        int k;
        ready = 1'b0;
        @(negedge i_clock);
        fq.push_back(RES); fq.push_back(MAG); fq.push_back(32'd6);
        for (int i = 0; i < 6; i++) fq.push_back(rnd_word());
        k = 0;
        while (!pv && k < 50) begin
            @(negedge i_clock);
            k++;
        end
        total++;
        if (!pv || st !== 2'd3) begin
            bad++;
            $display("FAIL reset_mid reach DATA got valid=%b state=%0d want valid=1 state=3", pv, st);
        end
        @(posedge i_clock); #2;
        i_reset_n = 1'b0;
        #1;
        total++;
        if (pv !== 1'b0 || st !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid async clear got valid=%b state=%0d want 0/0", pv, st);
        end
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        s = '{RES, MAG, 32'd2, 32'h0BADF00D, 32'h600DCAFE};
        run(s, 0, "reset_mid");
    endtask

    initial begin
        ready = 1'b1;
        test_reset();
        test_basic();
        test_garbage();
        test_len_err();
        test_resync_mid();
        test_backpressure();
        test_max_len();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_rx_packet_decoder.md
Name: pc_rx_packet_decoder

Overview:
- Consumes 32-bit words from the UART receive FIFO (PC_RX output side) and runs the packet-framing state machine.
- Detects the RESYNC word, the MAGIC_NUMBER word and a length header, then forwards only payload words to the DataManager over a valid/ready handshake.
- Generates the start-of-packet and end-of-packet strobes and counts framing errors.
- Sits between the PC_RX FIFO read port and the DataManager.

Parameters:
- RESYNC_WORD, 32'h416FDC1E, resync sequence 0x41,0x6F,0xDC,0x1E with the first byte in bits [31:24].
- MAGIC_WORD, 32'hD78C1B74, magic sequence 0xD7,0x8C,0x1B,0x74 with the first byte in bits [31:24].
- MAX_LEN, 1024, largest legal payload length in words.

Ports:
- i_clock  in  1  system clock; all logic is single-clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_fifo_word  in  32  FIFO q; valid in the cycle after o_fifo_rdreq (normal-mode FIFO).
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rdreq  out  1  FIFO read request; each assertion is a 1-cycle pulse.
- o_payload_word  out  32  payload word to the DataManager.
- o_payload_valid  out  1  o_payload_word is valid.
- i_payload_ready  in  1  DataManager accepts the word; handshake completes on valid&&ready.
- o_start_packet_sig  out  1  1-cycle pulse when a legal length header is accepted.
- o_packet_done_sig  out  1  1-cycle pulse on the handshake of the last payload word.
- o_state  out  2  current state: 0 IDLE, 1 PRE, 2 LEN, 3 DATA.
- o_resync_err_count  out  8  saturating count of RESYNC words received in LEN or DATA.
- o_len_err_count  out  8  saturating count of length headers equal to 0 or greater than MAX_LEN.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs 0.
  - Word counter = 0, outstanding-read flag = 0.
- Fetch rules:
  - At most one FIFO read is outstanding at a time.
  - o_fifo_rdreq asserts in cycle N only when all hold: !i_fifo_empty, no read outstanding, and no payload word held (o_payload_valid=0 or handshake completing in N).
  - In cycle N+1, i_fifo_word is sampled and classified.
- Classification by state (word sampled in cycle N+1):
  - IDLE: RESYNC -> PRE; any other word is discarded.
  - PRE: MAGIC -> LEN; RESYNC -> PRE; any other word -> IDLE.
  - LEN: RESYNC -> PRE and o_resync_err_count increments.
  - LEN: length L with 1 <= L <= MAX_LEN -> load counter with L, go to DATA, and pulse o_start_packet_sig in cycle N+2.
  - LEN: length 0 or greater than MAX_LEN -> IDLE and o_len_err_count increments.
  - DATA: RESYNC -> PRE, o_resync_err_count increments, and the word is not forwarded. Payload therefore must never contain RESYNC_WORD.
  - DATA: any other word is registered into o_payload_word, with o_payload_valid high from N+2.
- Payload handshake:
  - o_payload_word and o_payload_valid hold stable until the handshake completes.
  - On each handshake the counter decrements.
  - On the handshake that brings the counter to 0: o_packet_done_sig pulses in that same cycle, o_payload_valid drops the next cycle unless a new word lands, and state -> IDLE.
  - MAGIC_WORD inside DATA is treated as ordinary payload.
- Throughput: at most one word per 2 cycles. With ready held high, consecutive payload valids are 2 cycles apart.
- Boundaries:
  - i_fifo_empty high: no read is issued and state holds.
  - i_payload_ready low: reads stall, so FIFO backpressure is inherent.
  - Error counters saturate at 255 and never wrap.
  - Reset asserted mid-packet clears the held word and valid immediately; state -> IDLE. The FIFO is not flushed; residual words are discarded until the next RESYNC.
  - A length header of exactly MAX_LEN is legal.

Test Plan:
- Stream 416FDC1E, D78C1B74, 00000003, 11111111, 22222222, 33333333 with ready=1 -> exactly 3 payload handshakes in order; start pulse once; done pulse on 33333333; state returns to 0.
- Garbage 12345678, AAAAAAAA before RESYNC, then RESYNC followed by 00000000 instead of MAGIC -> no payload; state IDLE; len counters unchanged.
- RESYNC, MAGIC, length 0, then RESYNC, MAGIC, length MAX_LEN+1 -> o_len_err_count=2; no start pulse.
- RESYNC, MAGIC, length 4, two payload words, then RESYNC, MAGIC, length 1, word CAFEF00D -> o_resync_err_count=1; 3 payload words total; one done pulse (on CAFEF00D).
- Packet of length 5 with i_payload_ready toggling 1,0,0,1: word held stable while ready is low; no rdreq while a word is held; all 5 words delivered intact.
- Assert i_reset_n=0 in DATA with valid high -> valid=0 and state=0 asynchronously. After release, words up to the next RESYNC are dropped and a fresh packet decodes correctly.
